// File: rtl/hub75_scan_engine.sv
// rtl/hub75_scan_engine.sv - HUB75 1/8-scan engine: framebuffer walk, shift clock, latch, blanking and row address.
module hub75_scan_engine #(
    parameter int COLS           = 32,
    parameter int CLK_DIV        = 3,
    parameter int BLANK_CYCLES   = 4,
    parameter int LAT_CYCLES     = 2,
    parameter int DISPLAY_CYCLES = 256
) (
    input  logic                         Clkin,
    input  logic                         Rstn,
    input  logic                         En,
    output logic [3+$clog2(COLS)-1:0]    FbAddr,
    input  logic [5:0]                   FbData,
    output logic                         R1,
    output logic                         G1,
    output logic                         B1,
    output logic                         R2,
    output logic                         G2,
    output logic                         B2,
    output logic                         Clk,
    output logic                         Lat,
    output logic                         OE,
    output logic                         A,
    output logic                         B,
    output logic                         C,
    output logic                         FrameStart
);

    localparam int COL_W   = $clog2(COLS);
    localparam int P_MAX   = 2 * CLK_DIV - 1;
    localparam int P_W     = $clog2(2 * CLK_DIV);
    localparam int MAX_BL  = (BLANK_CYCLES > LAT_CYCLES) ? BLANK_CYCLES : LAT_CYCLES;
    localparam int CNT_MAX = (MAX_BL > DISPLAY_CYCLES) ? MAX_BL : DISPLAY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [P_W-1:0]         p_q, p_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [COL_W+2:0]       fbaddr_q;
    logic [5:0]             rgb_q;
    logic                   clk_q, lat_q, oe_q, fs_q;
    logic [2:0]             abc_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (En) begin
                    state_d = SHIFT;
                    col_d   = '0;
                    p_d     = '0;
                end
            end
            SHIFT: begin
                if (p_q == P_W'(P_MAX)) begin
                    p_d   = '0;
                    col_d = col_q + 1'b1;
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == CNT_W'(LAT_CYCLES - 1)) begin
                    state_d = DISPLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DISPLAY: begin
                if (cnt_q == CNT_W'(DISPLAY_CYCLES - 1)) begin
                    // En is only resampled here, so a disable mid-row still shows the row.
                    state_d = En ? SHIFT : IDLE;
                    row_d   = row_q + 3'd1;
                    cnt_d   = '0;
                    col_d   = '0;
                    p_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so each pin is glitch-free and aligned to its phase.
    always_ff @(posedge Clkin or negedge Rstn) begin
        if (!Rstn) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            fbaddr_q <= '0;
            rgb_q    <= '0;
            clk_q    <= 1'b0;
            lat_q    <= 1'b0;
            oe_q     <= 1'b1;
            abc_q    <= '0;
            fs_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            if (state_d == SHIFT && p_d == '0) begin
                fbaddr_q <= {row_d, col_d};
            end
            if (state_q == SHIFT && p_q == P_W'(1)) begin
                rgb_q <= FbData;
            end
            clk_q <= (state_d == SHIFT) && (p_d >= P_W'(CLK_DIV));
            lat_q <= (state_d == LATCH);
            oe_q  <= (state_d != DISPLAY);
            if (state_d == LATCH && state_q != LATCH) begin
                abc_q <= row_q;
            end
            fs_q <= (state_d == SHIFT) && (state_q != SHIFT) && (row_d == 3'd0);
        end
    end

    assign FbAddr                  = fbaddr_q;
    assign {R1, G1, B1, R2, G2, B2} = rgb_q;
    assign Clk                     = clk_q;
    assign Lat                     = lat_q;
    assign OE                      = oe_q;
    assign {C, B, A}               = abc_q;
    assign FrameStart              = fs_q;

endmodule

// File: tb/tb_hub75_scan_engine.sv
// tb/tb_hub75_scan_engine.sv - scoreboard bench for hub75_scan_engine with a synchronous framebuffer model.
module tb_hub75_scan_engine;

    logic       Clkin = 1'b0;
    logic       Rstn;
    logic       En;
    logic [7:0] FbAddr;
    logic [5:0] FbData;
    logic       R1, G1, B1, R2, G2, B2, Clk, Lat, OE, A, B, C, FrameStart;

    hub75_scan_engine dut (
        .Clkin(Clkin), .Rstn(Rstn), .En(En), .FbAddr(FbAddr), .FbData(FbData),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .Clk(Clk), .Lat(Lat), .OE(OE), .A(A), .B(B), .C(C), .FrameStart(FrameStart)
    );

    always #5 Clkin = ~Clkin;

    logic [5:0] fb [256];
    always @(posedge Clkin) FbData <= fb[FbAddr];

    int cyc = 0;
    always @(posedge Clkin) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] pix(input int r, input int c);
        return 6'((c + 8 * r) % 64);
    endfunction

    logic [5:0] pix_q [$];
    logic [2:0] lat_q [$];
    int         fs_q  [$];

    int   n_pix = 0, n_lat = 0, n_disp = 0;
    int   last_fall = 0, lat_run = 0, oe_run = 0;
    logic clk_p = 1'b0, lat_p = 1'b0, oe_p = 1'b1;
    logic drop_disp = 1'b0;

    always @(negedge Clkin) begin
        if (Rstn === 1'b1) begin
            if (Clk && !clk_p) begin
                if (pix_q.size() == 0) chk("unexpected_clk_edge", 1, 0);
                else chk("pixel_at_clk_rise", {26'd0, R1, G1, B1, R2, G2, B2}, {26'd0, pix_q.pop_front()});
                n_pix++;
            end
            if (!Clk && clk_p) last_fall = cyc;
            if (Lat && !lat_p) begin
                if (lat_q.size() == 0) chk("unexpected_latch", 1, 0);
                else chk("latch_row_cba", {29'd0, C, B, A}, {29'd0, lat_q.pop_front()});
                chk("blank_len", cyc - last_fall, 4);
                n_lat++;
                lat_run = 0;
            end
            if (Lat) begin
                lat_run++;
                chk("lat_vs_oe_clk", {30'd0, OE, Clk}, 32'b10);
            end
            if (!Lat && lat_p) chk("lat_len", lat_run, 2);
            if (!OE) oe_run++;
            if (OE && !oe_p) begin
                if (drop_disp) drop_disp = 1'b0;
                else chk("display_len", oe_run, 256);
                n_disp++;
                oe_run = 0;
            end
            if (FrameStart) begin
                if (fs_q.size() == 0) chk("unexpected_framestart", 1, 0);
                else chk("framestart_cycle", cyc, fs_q.pop_front());
            end
        end
        clk_p = Clk;
        lat_p = Lat;
        oe_p  = OE;
    end

    task automatic push_row(input int r);
        for (int c = 0; c < 32; c++) pix_q.push_back(pix(r, c));
        lat_q.push_back(3'(r));
    endtask

    task automatic wait_lat(input int target, input int budget);
        for (int i = 0; i < budget && n_lat < target; i++) @(negedge Clkin);
        chk("wait_latch_count", n_lat, target);
    endtask

    task automatic wait_disp(input int target, input int budget);
        for (int i = 0; i < budget && n_disp < target; i++) @(negedge Clkin);
        chk("wait_display_count", n_disp, target);
    endtask

    task automatic chk_idle_pins(input string name);
        chk(name, {19'd0, R1, G1, B1, R2, G2, B2, Clk, Lat, OE, C, B, A, FrameStart},
            {19'd0, 13'b000000_0_0_1_000_0});
    endtask

    int pix_snap;

    initial begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 32; c++) fb[r * 32 + c] = pix(r, c);
        Rstn = 1'b0;
        En   = 1'b0;
        repeat (5) @(negedge Clkin);
        chk_idle_pins("reset_pins");
        chk("reset_fbaddr", {24'd0, FbAddr}, 0);
        Rstn = 1'b1;
        repeat (100) @(negedge Clkin);
        chk_idle_pins("idle_pins");
        chk("idle_fbaddr", {24'd0, FbAddr}, 0);
        chk("idle_no_clk", n_pix, 0);

        // Rows 0..7, wrap to 0, then 1..3; En is dropped during row 3 shifting.
        for (int r = 0; r < 8; r++) push_row(r);
        for (int r = 0; r < 4; r++) push_row(r);
        fs_q.push_back(cyc + 1);
        fs_q.push_back(cyc + 1 + 3632);
        En = 1'b1;
        wait_lat(11, 6000);
        repeat (300) @(negedge Clkin);
        En = 1'b0;
        wait_disp(12, 1000);
        pix_snap = n_pix;
        repeat (50) @(negedge Clkin);
        chk("post_disable_oe", {31'd0, OE}, 1);
        chk("post_disable_no_clk", n_pix, pix_snap);
        chk("post_disable_abc", {29'd0, C, B, A}, 3);

        // Resume at row 4 without FrameStart, then reset during its display window.
        push_row(4);
        En = 1'b1;
        wait_lat(13, 1000);
        repeat (100) @(negedge Clkin);
        chk("mid_display_oe", {31'd0, OE}, 0);
        drop_disp = 1'b1;
        push_row(0);
        fs_q.push_back(cyc + 1);
        #1 Rstn = 1'b0;
        #1 chk("async_rst_pins", {28'd0, OE, Lat, Clk, C | B | A}, {28'd0, 4'b1000});
        chk("async_rst_fbaddr", {24'd0, FbAddr}, 0);
        #2 Rstn = 1'b1;
        wait_lat(14, 1000);
        En = 1'b0;
        wait_disp(14, 1000);
        repeat (20) @(negedge Clkin);
        chk("final_oe", {31'd0, OE}, 1);
        chk("final_pix_queue", pix_q.size(), 0);
        chk("final_lat_queue", lat_q.size(), 0);
        chk("final_fs_queue", fs_q.size(), 0);
        chk("final_pix_total", n_pix, 14 * 32);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
